// File: rtl/sqvt_vgen_pkg.sv
// Shared defaults and state encoding for the square-wave voltage generator family.
package sqvt_pkg;
    localparam int W_DEF  = 12;
    localparam int CW_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/sqvt_vgen_if.sv
// Control/settings inputs and sample/strobe outputs of the square-wave voltage generator.
interface sqvt_vgen_if #(
    parameter int W  = sqvt_pkg::W_DEF,
    parameter int CW = sqvt_pkg::CW_DEF
);
    logic          Start;
    logic          Stop;
    logic [W-1:0]  HighLvl;
    logic [W-1:0]  LowLvl;
    logic [CW-1:0] Period;
    logic [CW-1:0] Duty;
    logic [W-1:0]  Dout;
    logic          EN;
    logic          Busy;

    modport master (
        output Start, Stop, HighLvl, LowLvl, Period, Duty,
        input  Dout, EN, Busy
    );

    modport slave (
        input  Start, Stop, HighLvl, LowLvl, Period, Duty,
        output Dout, EN, Busy
    );
endinterface

// File: rtl/sqvt_vgen_en_dly.sv
// Fixed-depth strobe delay line with asynchronous active-low clear; matches the
// register latency of the downstream voltage path.
module sqvt_en_dly #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    output logic strobe_out
);
    logic [DEPTH:0] tap;

    assign tap[0] = strobe_in;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic stage_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= tap[gi];
                end
            end

            assign tap[gi+1] = stage_reg;
        end
    endgenerate

    assign strobe_out = tap[DEPTH];
endmodule

// File: rtl/sqvt_vgen.sv
// Square-wave level generator: shadowed period/duty/levels applied at period
// boundaries, registered sample output and a change strobe delayed to match the voltage path.
module sqvt_vgen
    import sqvt_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic        Clock,
    input  logic        Reset_n,
    sqvt_vgen_if.slave  bus
);
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] per_reg, per_next;
    logic [CW-1:0] duty_reg, duty_next;
    logic [W-1:0]  hi_reg, hi_next;
    logic [W-1:0]  lo_reg, lo_next;
    logic [W-1:0]  dout_reg, dout_next;
    logic          chg_reg, chg_next;
    logic          wrap;
    logic          load;
    logic          first_run;
    logic          en;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            per_reg   <= '0;
            duty_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            dout_reg  <= '0;
            chg_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            per_reg   <= per_next;
            duty_reg  <= duty_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            dout_reg  <= dout_next;
            chg_reg   <= chg_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        per_next   = per_reg;
        duty_next  = duty_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        dout_next  = dout_reg;
        load       = 1'b0;
        first_run  = 1'b0;
        // A period of 0 or 1 wraps every cycle; avoids the underflow of per_reg-1.
        wrap       = (per_reg <= CW'(1)) || (cnt_reg == per_reg - CW'(1));

        case (state_reg)
            IDLE: begin
                if (bus.Start && !bus.Stop) begin
                    state_next = RUN;
                    load       = 1'b1;
                    first_run  = 1'b1;
                end
            end
            RUN: begin
                if (bus.Stop) begin
                    state_next = IDLE;
                    dout_next  = bus.LowLvl;
                end else if (wrap) begin
                    load = 1'b1;
                end else begin
                    cnt_next  = cnt_reg + CW'(1);
                    dout_next = (cnt_next < duty_reg) ? hi_reg : lo_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Period start: fresh shadows, and the level for cnt=0 uses them directly.
        if (load) begin
            cnt_next  = '0;
            per_next  = bus.Period;
            duty_next = bus.Duty;
            hi_next   = bus.HighLvl;
            lo_next   = bus.LowLvl;
            dout_next = (bus.Duty != '0) ? bus.HighLvl : bus.LowLvl;
        end

        chg_next = first_run || (dout_next != dout_reg);
    end

    sqvt_en_dly #(
        .DEPTH (2)
    ) u_en_dly (
        .clk        (Clock),
        .rst_n      (Reset_n),
        .strobe_in  (chg_reg),
        .strobe_out (en)
    );

    assign bus.Dout = dout_reg;
    assign bus.EN   = en;
    assign bus.Busy = (state_reg == RUN);
endmodule

// File: tb/tb_sqvt_vgen.sv
// Self-checking bench for sqvt_vgen: directed scenarios plus randomized settings
// against a period-position reference model.
module tb_sqvt_vgen;
    import sqvt_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sqvt_vgen_if #(.W(12), .CW(16)) bus ();

    sqvt_vgen #(.W(12), .CW(16)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within the current period and the settings
    // captured at the start of that period.
    bit m_run;
    int m_pos, m_per, m_duty, m_hi, m_lo, m_dout;
    bit c0, c1, m_en;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_per = 0; m_duty = 0;
        m_hi = 0; m_lo = 0; m_dout = 0;
        c0 = 0; c1 = 0; m_en = 0;
    endtask

    task automatic model_load();
        m_per  = int'(bus.Period);
        m_duty = int'(bus.Duty);
        m_hi   = int'(bus.HighLvl);
        m_lo   = int'(bus.LowLvl);
    endtask

    task automatic model_edge();
        int prev;
        bit first;
        bit chg;
        int eff_per;
        prev  = m_dout;
        first = 0;
        if (!m_run) begin
            if (bus.Start && !bus.Stop) begin
                m_run = 1;
                first = 1;
                model_load();
                m_pos  = 0;
                m_dout = (m_pos < m_duty) ? m_hi : m_lo;
            end
        end else if (bus.Stop) begin
            m_run  = 0;
            m_dout = int'(bus.LowLvl);
        end else begin
            eff_per = (m_per == 0) ? 1 : m_per;
            m_pos++;
            if (m_pos >= eff_per) begin
                m_pos = 0;
                model_load();
            end
            m_dout = (m_pos < m_duty) ? m_hi : m_lo;
        end
        chg  = first || (m_dout != prev);
        m_en = c1;
        c1   = c0;
        c0   = chg;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".dout"}, 32'(bus.Dout), 32'(m_dout));
        check_val({tag, ".en"},   32'(bus.EN),   32'(m_en));
        check_val({tag, ".busy"}, 32'(bus.Busy), 32'(m_run));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        check_outputs(tag);
    endtask

    task automatic set_cfg(input int hi, input int lo, input int per, input int duty);
        bus.HighLvl = 12'(hi);
        bus.LowLvl  = 12'(lo);
        bus.Period  = 16'(per);
        bus.Duty    = 16'(duty);
    endtask

    task automatic randomize_inputs();
        bus.Start   = ($urandom % 4) == 0;
        bus.Stop    = ($urandom % 16) == 0;
        bus.Period  = 16'($urandom_range(0, 7));
        bus.Duty    = 16'($urandom_range(0, 8));
        bus.HighLvl = 12'($urandom);
        bus.LowLvl  = (($urandom % 4) == 0) ? bus.HighLvl : 12'($urandom);
    endtask

    task automatic go_idle();
        bus.Start = 0;
        bus.Stop  = 1;
        tick("stop");
        tick("stop");
        tick("stop");
        bus.Stop = 0;
    endtask

    logic [11:0] basic_dout [8] = '{12'hFFF, 12'h000, 12'h000, 12'h000,
                                    12'hFFF, 12'h000, 12'h000, 12'h000};
    logic        basic_en   [8] = '{0, 0, 1, 1, 0, 0, 1, 1};

    initial begin
        model_reset();
        bus.Start = 0; bus.Stop = 0;
        set_cfg(0, 0, 0, 0);

        // Reset held with toggling inputs
        #2;
        check_outputs("rst_init");
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            bus.Start = 1;
            bus.Stop  = 0;
            tick("rst_hold");
        end
        rst_n = 1;
        bus.Start = 0;
        for (int i = 0; i < 5; i++) tick("idle_after_rst");
        $display("[TB] reset scenario done, %0d failures so far", n_fail);

        // Basic waveform with explicit constant pattern
        set_cfg(12'hFFF, 12'h000, 4, 1);
        bus.Start = 1;
        for (int k = 0; k < 8; k++) begin
            tick("basic");
            check_val("basic.dout_pat", 32'(bus.Dout), 32'(basic_dout[k]));
            check_val("basic.en_pat",   32'(bus.EN),   32'(basic_en[k]));
        end
        $display("[TB] basic waveform done, %0d failures so far", n_fail);

        // Boundary update: change settings at cnt=1 of a period
        go_idle();
        set_cfg(12'hFFF, 12'h000, 4, 1);
        bus.Start = 1;
        tick("bnd");
        bus.Start = 0;
        tick("bnd");
        set_cfg(12'hFFF, 12'h000, 6, 3);
        for (int k = 0; k < 16; k++) tick("bnd");
        $display("[TB] boundary update done, %0d failures so far", n_fail);

        // Degenerate settings
        go_idle();
        set_cfg(12'hABC, 12'h123, 4, 0);
        bus.Start = 1;
        for (int k = 0; k < 8; k++) tick("duty0");
        go_idle();
        set_cfg(12'hABC, 12'h123, 5, 9);
        bus.Start = 1;
        for (int k = 0; k < 10; k++) tick("duty_ge_per");
        check_val("duty_ge_per.high", 32'(bus.Dout), 32'h0ABC);
        go_idle();
        set_cfg(12'h7A5, 12'h05A, 0, 1);
        bus.Start = 1;
        for (int k = 0; k < 6; k++) tick("per0");
        check_val("per0.high", 32'(bus.Dout), 32'h07A5);
        go_idle();
        set_cfg(12'h555, 12'h555, 3, 1);
        bus.Start = 1;
        for (int k = 0; k < 8; k++) tick("hi_eq_lo");
        $display("[TB] degenerate settings done, %0d failures so far", n_fail);

        // Stop while high, then Start+Stop together
        go_idle();
        set_cfg(12'hFFF, 12'h010, 6, 4);
        bus.Start = 1;
        tick("stop_hi");
        tick("stop_hi");
        bus.Stop = 1;
        tick("stop_hi");
        check_val("stop_hi.busy", 32'(bus.Busy), 32'd0);
        check_val("stop_hi.dout", 32'(bus.Dout), 32'h010);
        bus.Stop = 0;
        bus.Start = 0;
        tick("stop_hi");
        tick("stop_hi");
        check_val("stop_hi.en", 32'(bus.EN), 32'd1);
        bus.Start = 1;
        bus.Stop  = 1;
        for (int k = 0; k < 4; k++) tick("start_stop");
        bus.Stop = 0;
        bus.Start = 0;
        $display("[TB] stop scenarios done, %0d failures so far", n_fail);

        // Reset pulse mid-run with an EN in flight
        set_cfg(12'hFFF, 12'h000, 4, 1);
        bus.Start = 1;
        tick("rst_mid");
        tick("rst_mid");
        rst_n = 0;
        #1;
        model_reset();
        check_outputs("rst_mid_async");
        tick("rst_mid_low");
        rst_n = 1;
        bus.Start = 0;
        for (int k = 0; k < 4; k++) tick("rst_mid_after");
        bus.Start = 1;
        for (int k = 0; k < 6; k++) tick("rst_mid_restart");
        $display("[TB] reset mid-run done, %0d failures so far", n_fail);

        // Randomized settings and control
        for (int k = 0; k < 400; k++) begin
            randomize_inputs();
            tick("rand");
        end
        $display("[TB] random phase done, %0d failures so far", n_fail);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
